cone_bist_ctrl: RTL and testbench

- Built-in self-test sequencer for one extracted combinational cone of the s15850 partial-output netlists: 20 primary inputs, 1 output.
- A 20-bit LFSR generates the patterns and drives them onto the cone inputs.
- The cone output is captured into a 16-bit serial MISR (signature register).
- After the programmed pattern count, the signature is compared against a golden value and pass/fail is reported.
- Sits beside each combinational cone in the fault-injection/reliability harness.

---
 rtl/cone_bist_ctrl_if.sv | 34 +++
 rtl/cone_bist_ctrl.sv | 156 +++++++++++++++
 tb/tb_cone_bist_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cone_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cone_bist_ctrl_if
//  Description : Control/observation bundle between a cone BIST sequencer
//                and the harness that owns the cone under test.
//  Revision    : 1.0  initial release
// ============================================================================
interface cone_bist_ctrl_if #(
    parameter int PAT_W = 20,
    parameter int CNT_W = 11
);
    logic             start;
    logic             abort;
    logic             cone_out;
    logic [PAT_W-1:0] cone_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [15:0]      signature;
    logic [CNT_W-1:0] pat_cnt;

    // Harness side: requests runs and returns the cone response
    modport master (
        output start, abort, cone_out,
        input  cone_in, busy, done, pass, signature, pat_cnt
    );

    // Sequencer side
    modport slave (
        input  start, abort, cone_out,
        output cone_in, busy, done, pass, signature, pat_cnt
    );
endinterface
`default_nettype wire

// File: rtl/cone_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cone_bist_ctrl
//  Description : BIST sequencer for one combinational cone. A 20-bit
//                Fibonacci LFSR (x^20+x^17+1) drives the cone inputs, the
//                single cone output is compacted by a serial CRC-CCITT MISR,
//                and after NUM_PATTERNS captures the signature is compared
//                against GOLDEN.
//                Optional macro CONE_BIST_SETTLE_EN inserts a SETTLE state of
//                SETTLE_CYC cycles between APPLY and CAPTURE.
//  Revision    : 1.0  initial release
// ============================================================================
module cone_bist_ctrl #(
    parameter int               PAT_W        = 20,
    parameter int               NUM_PATTERNS = 1024,
    parameter logic [PAT_W-1:0] SEED         = 20'h00001,
    parameter logic [15:0]      SIG_INIT     = 16'hFFFF,
    parameter logic [15:0]      GOLDEN       = 16'h0000
`ifdef CONE_BIST_SETTLE_EN
   ,parameter int               SETTLE_CYC   = 2
`endif
) (
    input  wire logic       CK,
    input  wire logic       reset,
    cone_bist_ctrl_if.slave bus
);

    localparam int               CNT_W    = $clog2(NUM_PATTERNS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);
    // An all-zero LFSR would lock up, so a zero seed is replaced by 1
    localparam logic [PAT_W-1:0] SEED_EFF = (SEED == '0) ? PAT_W'(1) : SEED;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        APPLY   = 3'd2,
        CAPTURE = 3'd3,
        CHECK   = 3'd4,
        DONE    = 3'd5
`ifdef CONE_BIST_SETTLE_EN
       ,SETTLE  = 3'd6
`endif
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PAT_W-1:0]   lfsr;
    logic [PAT_W-1:0]   cone_in_q;
    logic [15:0]        misr;
    logic [CNT_W-1:0]   pat_cnt_q;
    logic               pass_q;

    logic [PAT_W-1:0]   lfsr_next;
    logic               misr_fb;
    logic [15:0]        misr_next;

    assign lfsr_next = {lfsr[PAT_W-2:0], lfsr[PAT_W-1] ^ lfsr[PAT_W-4]};
    assign misr_fb   = misr[15] ^ bus.cone_out;
    assign misr_next = {misr[14:0], 1'b0} ^ (misr_fb ? 16'h1021 : 16'h0000);

`ifdef CONE_BIST_SETTLE_EN
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    logic [SET_W-1:0] settle_cnt;

    // Settle down-counter: loaded in APPLY, reaches zero on the last SETTLE cycle
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if (state == APPLY) begin
            settle_cnt <= SET_LOAD;
        end else if ((state == SETTLE) && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - SET_W'(1);
        end
    end
`endif

    // State register
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        state_next = state;
        if (bus.abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.start) state_next = LOAD;
                LOAD:    state_next = APPLY;
`ifdef CONE_BIST_SETTLE_EN
                APPLY:   state_next = (SETTLE_CYC > 0) ? SETTLE : CAPTURE;
                SETTLE:  if (settle_cnt == '0) state_next = CAPTURE;
`else
                APPLY:   state_next = CAPTURE;
`endif
                CAPTURE: state_next = (pat_cnt_q == LAST_CNT) ? CHECK : APPLY;
                CHECK:   state_next = DONE;
                DONE:    if (bus.start) state_next = LOAD;
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath: LFSR, pattern latch, MISR, pattern counter and verdict.
    // The pattern latch is written on entry to APPLY so the cone sees a
    // stable value throughout APPLY (and SETTLE) and CAPTURE. An abort
    // freezes signature and count so a partial run can be inspected.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            lfsr      <= SEED_EFF;
            cone_in_q <= '0;
            misr      <= SIG_INIT;
            pat_cnt_q <= '0;
            pass_q    <= 1'b0;
        end else if (bus.abort) begin
            pass_q    <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    lfsr      <= SEED_EFF;
                    cone_in_q <= SEED_EFF;
                    misr      <= SIG_INIT;
                    pat_cnt_q <= '0;
                    pass_q    <= 1'b0;
                end
                CAPTURE: begin
                    misr      <= misr_next;
                    lfsr      <= lfsr_next;
                    cone_in_q <= lfsr_next;
                    pat_cnt_q <= pat_cnt_q + CNT_W'(1);
                end
                CHECK: begin
                    pass_q    <= (misr == GOLDEN);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.cone_in   = cone_in_q;
    assign bus.signature = misr;
    assign bus.pat_cnt   = pat_cnt_q;
    assign bus.pass      = pass_q;
    assign bus.done      = (state == DONE);
    assign bus.busy      = (state != IDLE) && (state != DONE);

endmodule
`default_nettype wire

// File: tb/tb_cone_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cone_bist_ctrl
//  Description : Scoreboard bench for cone_bist_ctrl. The bench plays the
//                cone (parity of masked inputs, optionally inverted) and
//                predicts patterns, signature, verdict and done timing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cone_bist_ctrl;

    localparam int          N         = 4;
    localparam logic [19:0] TB_SEED   = 20'h00000;
    localparam logic [15:0] TB_GOLDEN = 16'h0E1F;
    localparam int          CNT_W     = $clog2(N + 1);
`ifdef CONE_BIST_SETTLE_EN
    localparam int          SETTLE    = 2;
`else
    localparam int          SETTLE    = 0;
`endif
    localparam int          STEP      = 2 + SETTLE;
    localparam int          LAT       = STEP * N + 2;

    typedef struct {
        logic [15:0] sig;
        logic        pass;
        int          done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] cone_mask;
    logic        cone_inv;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          runs_done = 0;

    exp_t        sb[$];
    logic [19:0] exp_pat[$];

    cone_bist_ctrl_if #(.PAT_W(20), .CNT_W(CNT_W)) bus ();

    cone_bist_ctrl #(
        .PAT_W        (20),
        .NUM_PATTERNS (N),
        .SEED         (TB_SEED),
        .SIG_INIT     (16'hFFFF),
        .GOLDEN       (TB_GOLDEN)
    ) dut (
        .CK    (clk),
        .reset (reset),
        .bus   (bus)
    );

    // The cone under test: parity of the masked pattern bits
    assign bus.cone_out = (^(bus.cone_in & cone_mask)) ^ cone_inv;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [19:0] model_pat(input int idx);
        int unsigned p;
        p = (TB_SEED == 20'h0) ? 1 : int'(TB_SEED);
        for (int i = 0; i < idx; i++)
            p = ((p << 1) & 32'h000F_FFFF) | (((p >> 19) ^ (p >> 16)) & 1);
        return p[19:0];
    endfunction

    function automatic logic [15:0] model_sig(input logic [19:0] mask, input logic inv,
                                              input int count);
        int unsigned s;
        int unsigned b;
        s = 32'hFFFF;
        for (int i = 0; i < count; i++) begin
            b = ($countones(model_pat(i) & mask) % 2) ^ int'(inv);
            s = (s << 1) ^ (((((s >> 15) & 1) ^ b) != 0) ? 32'h1021 : 32'h0);
            s = s & 32'hFFFF;
        end
        return s[15:0];
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    task automatic wait_runs(input int target, input int budget);
        int n;
        n = 0;
        while (runs_done < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (runs_done < target) fail("done_timeout");
    endtask

    // ---------------- monitor ----------------
    int          prev_cnt = 0;
    logic        prev_done = 1'b0;
    logic [19:0] prev_cone = '0;
    exp_t        mon_e;
    logic [19:0] mon_p;

    always @(negedge clk) begin
        if (!reset) begin
            // A count step means the pattern seen last cycle was captured
            if (bus.busy && int'(bus.pat_cnt) == prev_cnt + 1) begin
                if (exp_pat.size() == 0) begin
                    fail("pattern_unexpected");
                end else begin
                    mon_p = exp_pat.pop_front();
                    check("pattern", 32'(prev_cone), 32'(mon_p));
                end
            end
            if (bus.done && !prev_done) begin
                runs_done++;
                if (sb.size() == 0) begin
                    fail("done_unexpected");
                end else begin
                    mon_e = sb.pop_front();
                    check("signature", 32'(bus.signature), 32'(mon_e.sig));
                    check("pass", 32'(bus.pass), 32'(mon_e.pass));
                    check("pat_cnt_final", 32'(bus.pat_cnt), 32'(N));
                    check("done_cycle", cyc, mon_e.done_cyc);
                end
            end
        end
        prev_cnt  = int'(bus.pat_cnt);
        prev_done = bus.done;
        prev_cone = bus.cone_in;
    end

    // ---------------- stimulus ----------------
    task automatic push_run(input logic [19:0] mask, input logic inv, input int done_cyc);
        exp_t e;
        e.sig      = model_sig(mask, inv, N);
        e.pass     = (e.sig == TB_GOLDEN);
        e.done_cyc = done_cyc;
        sb.push_back(e);
    endtask

    task automatic run_one(input logic [19:0] mask, input logic inv, input logic mid);
        int k;
        int j;
        int target;
        @(negedge clk);
        cone_mask = mask;
        cone_inv  = inv;
        for (int i = 0; i < N; i++) exp_pat.push_back(model_pat(i));
        target    = runs_done + 1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        k         = cyc;
        bus.start = 1'b0;
        push_run(mask, inv, k + LAT);
        if (mid) begin
            // A start pulse while busy must not disturb the run
            j = $urandom_range(1, 2 * N + 2);
            repeat (j) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_runs(target, LAT + 10);
    endtask

    initial begin
        int k;
        int target;
        logic [19:0] m;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        cone_mask = '0;
        cone_inv  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cone_in", 32'(bus.cone_in), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_pass", 32'(bus.pass), 32'h0);
        check("rst_signature", 32'(bus.signature), 32'hFFFF);
        check("rst_pat_cnt", 32'(bus.pat_cnt), 32'h0);
        reset = 1'b0;

        // Cone tied low, zero seed: patterns 1,2,4,8 and signature 0x0E1F
        run_one(20'h0, 1'b0, 1'b0);

        // Abort during the third CAPTURE
        @(negedge clk);
        cone_mask = '0;
        cone_inv  = 1'b0;
        exp_pat.push_back(model_pat(0));
        exp_pat.push_back(model_pat(1));
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3 * STEP + 1) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_done", 32'(bus.done), 32'h0);
        check("abort_pass", 32'(bus.pass), 32'h0);
        check("abort_pat_cnt", 32'(bus.pat_cnt), 32'd2);
        check("abort_signature", 32'(bus.signature), 32'(model_sig(20'h0, 1'b0, 2)));
        exp_pat.delete();
        repeat (2) @(negedge clk);
        check("abort_stays_idle", 32'(bus.busy), 32'h0);

        // Rerun after abort
        run_one(20'h0, 1'b0, 1'b0);

        // start held high through DONE: one-cycle done, immediate restart
        @(negedge clk);
        cone_mask = '0;
        cone_inv  = 1'b0;
        for (int i = 0; i < 2 * N; i++) exp_pat.push_back(model_pat(i % N));
        target    = runs_done + 1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        push_run(20'h0, 1'b0, k + LAT);
        push_run(20'h0, 1'b0, k + 2 * LAT + 1);
        wait_runs(target, LAT + 10);
        @(posedge clk);
        #1;
        check("held_done_pulse", 32'(bus.done), 32'h0);
        check("held_restart_busy", 32'(bus.busy), 32'h1);
        bus.start = 1'b0;
        wait_runs(target + 1, LAT + 10);

        // Randomised cones, idle gaps and stray start pulses
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            m = 20'($urandom);
            run_one(m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of APPLY
        @(negedge clk);
        cone_mask = 20'($urandom);
        cone_inv  = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_cone_in", 32'(bus.cone_in), 32'h0);
        check("arst_busy", 32'(bus.busy), 32'h0);
        check("arst_done", 32'(bus.done), 32'h0);
        check("arst_pass", 32'(bus.pass), 32'h0);
        check("arst_signature", 32'(bus.signature), 32'hFFFF);
        check("arst_pat_cnt", 32'(bus.pat_cnt), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        exp_pat.delete();

        // Recovery run after reset
        run_one(20'($urandom), 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("pat_drained", exp_pat.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
